// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_stage
// Purpose  : Write-back / commit stage. Retires one instruction per cycle,
//            waits for load data, formats loads and drives the RF write port.
// Options  : WB_FORWARD_EN - mirrors the RF write port onto fwd_* for bypass.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_stage #(
    parameter int Inst_Size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Inst_Size-1:0] alu_result,
    input  logic [Inst_Size-1:0] pc_plus4,
    input  logic [4:0]           rd,
    input  logic [2:0]           func3,
    input  logic [1:0]           addr_lo,
    input  logic [1:0]           wb_sel,
    input  logic                 reg_write,
    input  logic                 mem_rsp_valid,
    input  logic [Inst_Size-1:0] mem_rdata,
    output logic                 wr_en,
    output logic [4:0]           wr_rd,
    output logic [Inst_Size-1:0] write_data,
    output logic                 busy,
    output logic [31:0]          retire_cnt,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [Inst_Size-1:0] fwd_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    localparam logic [1:0] c_sel_alu  = 2'b00;
    localparam logic [1:0] c_sel_load = 2'b01;
    localparam logic [1:0] c_sel_pc   = 2'b10;
    localparam logic [1:0] c_sel_none = 2'b11;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [4:0]             r_rd;
    logic [2:0]             r_func3;
    logic [1:0]             r_addr_lo;
    logic [1:0]             r_wb_sel;
    logic                   r_reg_write;
    logic [Inst_Size-1:0]   r_value;
    logic [31:0]            r_retire_cnt;

    logic                   w_xfer;
    logic                   w_commit;
    logic [Inst_Size-1:0]   w_direct;
    logic [Inst_Size-1:0]   w_load_value;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;

    assign w_xfer = in_valid && (r_state != WAIT_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b1;
        busy         = 1'b0;
        case (r_state)
            WAIT_LOAD: begin
                in_ready = 1'b0;
                busy     = 1'b1;
                if (mem_rsp_valid) begin
                    w_next_state = COMMIT;
                end
            end
            default: begin
                if (w_xfer) begin
                    w_next_state = (wb_sel == c_sel_load) ? WAIT_LOAD : COMMIT;
                end else begin
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_direct = '0;
        case (wb_sel)
            c_sel_alu: w_direct = alu_result;
            c_sel_pc:  w_direct = pc_plus4;
            default:   w_direct = '0;
        endcase
    end

    // Byte lane chosen by full offset, halfword lane by offset bit 1 only.
    assign w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        w_load_value = mem_rdata;
        case (r_func3)
            3'b000:  w_load_value = {{(Inst_Size-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_value = {{(Inst_Size-8){1'b0}}, w_byte};
            3'b001:  w_load_value = {{(Inst_Size-16){w_half[15]}}, w_half};
            3'b101:  w_load_value = {{(Inst_Size-16){1'b0}}, w_half};
            default: w_load_value = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd         <= '0;
            r_func3      <= '0;
            r_addr_lo    <= '0;
            r_wb_sel     <= '0;
            r_reg_write  <= 1'b0;
            r_value      <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_rd        <= rd;
                r_reg_write <= reg_write;
                r_wb_sel    <= wb_sel;
                if (wb_sel == c_sel_load) begin
                    r_func3   <= func3;
                    r_addr_lo <= addr_lo;
                end else begin
                    r_value <= w_direct;
                end
            end else if ((r_state == WAIT_LOAD) && mem_rsp_valid) begin
                r_value <= w_load_value;
            end
            // Counted on entry so the count already includes the instruction
            // being committed while it is visible on the write port.
            if (w_next_state == COMMIT) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign w_commit   = (r_state == COMMIT);
    assign wr_en      = w_commit && r_reg_write && (r_wb_sel != c_sel_none) && (r_rd != 5'd0);
    assign wr_rd      = w_commit ? r_rd : 5'd0;
    assign write_data = w_commit ? r_value : '0;
    assign retire_cnt = r_retire_cnt;

`ifdef WB_FORWARD_EN
    assign fwd_valid = wr_en;
    assign fwd_rd    = wr_rd;
    assign fwd_data  = write_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_stage
// Purpose  : Self-checking bench: directed vector table, reset corner case and
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit_stage;

    localparam int c_w = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [c_w-1:0] alu_result;
    logic [c_w-1:0] pc_plus4;
    logic [4:0]     rd;
    logic [2:0]     func3;
    logic [1:0]     addr_lo;
    logic [1:0]     wb_sel;
    logic           reg_write;
    logic           mem_rsp_valid;
    logic [c_w-1:0] mem_rdata;
    logic           wr_en;
    logic [4:0]     wr_rd;
    logic [c_w-1:0] write_data;
    logic           busy;
    logic [31:0]    retire_cnt;
    logic           fwd_valid;
    logic [4:0]     fwd_rd;
    logic [c_w-1:0] fwd_data;

    wb_commit_stage #(.Inst_Size(c_w)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .rd(rd), .func3(func3),
        .addr_lo(addr_lo), .wb_sel(wb_sel), .reg_write(reg_write),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .wr_en(wr_en),
        .wr_rd(wr_rd), .write_data(write_data), .busy(busy),
        .retire_cnt(retire_cnt), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding instruction, described as a transaction.
    logic        m_waiting;
    logic [4:0]  m_ld_rd;
    logic [2:0]  m_ld_f3;
    logic [1:0]  m_ld_off;
    logic        m_ld_rw;
    logic        m_commit;
    logic        m_en;
    logic        m_chk_data;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (32'(off) * 8)) & 32'hFF;
        h = (d >> (32'(off[1]) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        m_waiting = 1'b0; m_ld_rd = '0; m_ld_f3 = '0; m_ld_off = '0; m_ld_rw = 1'b0;
        m_commit = 1'b0; m_en = 1'b0; m_chk_data = 1'b1; m_rd = '0; m_data = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        m_commit   = 1'b0;
        m_chk_data = 1'b1;
        if (m_waiting) begin
            if (mem_rsp_valid) begin
                m_waiting = 1'b0;
                m_commit  = 1'b1;
                m_rd      = m_ld_rd;
                m_en      = m_ld_rw && (m_ld_rd != 0);
                m_data    = load_ref(m_ld_f3, m_ld_off, mem_rdata);
            end
        end else if (in_valid) begin
            if (wb_sel == 2'd1) begin
                m_waiting = 1'b1;
                m_ld_rd = rd; m_ld_f3 = func3; m_ld_off = addr_lo; m_ld_rw = reg_write;
            end else begin
                m_commit   = 1'b1;
                m_rd       = rd;
                m_en       = reg_write && (wb_sel != 2'd3) && (rd != 0);
                m_data     = (wb_sel == 2'd0) ? alu_result : pc_plus4;
                m_chk_data = (wb_sel != 2'd3);
            end
        end
        if (m_commit) m_cnt = m_cnt + 1;
    endtask

    task automatic model_check(input string tag);
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        e_en   = m_commit && m_en;
        e_rd   = m_commit ? m_rd : 5'd0;
        e_data = m_commit ? m_data : 32'd0;
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(e_en));
        chk({tag, ".wr_rd"}, 32'(wr_rd), 32'(e_rd));
        if (m_chk_data) chk({tag, ".write_data"}, write_data, e_data);
        chk({tag, ".busy"}, 32'(busy), 32'(m_waiting));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_waiting));
        chk({tag, ".retire_cnt"}, retire_cnt, m_cnt);
`ifdef WB_FORWARD_EN
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(e_en));
        chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(e_rd));
        if (m_chk_data) chk({tag, ".fwd_data"}, fwd_data, e_data);
`else
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'd0);
        chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'd0);
        chk({tag, ".fwd_data"}, fwd_data, 32'd0);
`endif
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] r,
                         input logic [2:0] f3, input logic [1:0] off, input logic rw,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic rv, input logic [31:0] rdat);
        in_valid = v; wb_sel = sel; rd = r; func3 = f3; addr_lo = off; reg_write = rw;
        alu_result = alu; pc_plus4 = pc; mem_rsp_valid = rv; mem_rdata = rdat;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [4:0]  r;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        rv;
        logic [31:0] rdat;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        chk_data;
        logic        e_busy;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [21];

    initial begin
        // inputs                                         expected after the edge
        vecs[0]  = '{1,2'd0, 5,3'd0,2'd0,1,32'h0000_1234,0,0,0,            1, 5,32'h0000_1234,1,0, 1};
        vecs[1]  = '{0,2'd0, 0,3'd0,2'd0,0,0,0,0,0,                        0, 0,32'h0,       1,0, 1};
        vecs[2]  = '{1,2'd1, 7,3'd0,2'd2,1,0,0,0,0,                        0, 0,32'h0,       1,1, 1};
        vecs[3]  = '{0,2'd0, 0,3'd0,2'd0,0,0,0,0,0,                        0, 0,32'h0,       1,1, 1};
        vecs[4]  = '{0,2'd0, 0,3'd0,2'd0,0,0,0,0,0,                        0, 0,32'h0,       1,1, 1};
        vecs[5]  = '{0,2'd0, 0,3'd0,2'd0,0,0,0,1,32'h1280_FF00,            1, 7,32'hFFFF_FF80,1,0, 2};
        vecs[6]  = '{1,2'd1, 9,3'd5,2'd2,1,0,0,0,0,                        0, 0,32'h0,       1,1, 2};
        vecs[7]  = '{0,2'd0, 0,3'd0,2'd0,0,0,0,1,32'h8001_0000,            1, 9,32'h0000_8001,1,0, 3};
        vecs[8]  = '{1,2'd1,10,3'd1,2'd2,1,0,0,0,0,                        0, 0,32'h0,       1,1, 3};
        vecs[9]  = '{0,2'd0, 0,3'd0,2'd0,0,0,0,1,32'h8001_0000,            1,10,32'hFFFF_8001,1,0, 4};
        vecs[10] = '{1,2'd0, 0,3'd0,2'd0,1,32'hDEAD_BEEF,0,0,0,            0, 0,32'hDEAD_BEEF,1,0, 5};
        vecs[11] = '{1,2'd0, 1,3'd0,2'd0,1,32'h11,0,0,0,                   1, 1,32'h11,      1,0, 6};
        vecs[12] = '{1,2'd0, 2,3'd0,2'd0,1,32'h22,0,0,0,                   1, 2,32'h22,      1,0, 7};
        vecs[13] = '{1,2'd0, 3,3'd0,2'd0,1,32'h33,0,0,0,                   1, 3,32'h33,      1,0, 8};
        vecs[14] = '{0,2'd0, 0,3'd0,2'd0,0,0,0,0,0,                        0, 0,32'h0,       1,0, 8};
        vecs[15] = '{1,2'd2, 4,3'd0,2'd0,1,32'h5,32'h100,0,0,              1, 4,32'h100,     1,0, 9};
        vecs[16] = '{0,2'd0, 0,3'd0,2'd0,0,0,0,1,32'h5555_5555,            0, 0,32'h0,       1,0, 9};
        vecs[17] = '{1,2'd1, 6,3'd2,2'd1,1,0,0,0,0,                        0, 0,32'h0,       1,1, 9};
        vecs[18] = '{1,2'd0,12,3'd0,2'd0,1,32'h77,0,1,32'hCAFE_F00D,       1, 6,32'hCAFE_F00D,1,0,10};
        vecs[19] = '{0,2'd0, 0,3'd0,2'd0,0,0,0,0,0,                        0, 0,32'h0,       1,0,10};
        vecs[20] = '{1,2'd3, 8,3'd0,2'd0,1,32'h99,0,0,0,                   0, 8,32'h0,       0,0,11};
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.wr_en", 32'(wr_en), 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.retire_cnt", retire_cnt, 0);
        chk("reset.write_data", write_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready_after_release", 32'(in_ready), 1);

        // Directed vector table
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].r, vecs[i].f3, vecs[i].off, vecs[i].rw,
                  vecs[i].alu, vecs[i].pc, vecs[i].rv, vecs[i].rdat);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.wr_en", i), 32'(wr_en), 32'(vecs[i].e_en));
            chk($sformatf("vec%0d.wr_rd", i), 32'(wr_rd), 32'(vecs[i].e_rd));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d.write_data", i), write_data, vecs[i].e_data);
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(!vecs[i].e_busy));
            chk($sformatf("vec%0d.retire_cnt", i), retire_cnt, vecs[i].e_cnt);
        end

        // Reset while a load is outstanding, then a stale response
        drive(1, 2'd0, 5, 0, 0, 1, 32'h0000_1234, 0, 0, 0);
        step("fwd");
`ifdef WB_FORWARD_EN
        chk("fwd.valid", 32'(fwd_valid), 1);
        chk("fwd.rd", 32'(fwd_rd), 5);
        chk("fwd.data", fwd_data, 32'h0000_1234);
`else
        chk("fwd.valid_tied", 32'(fwd_valid), 0);
        chk("fwd.data_tied", fwd_data, 0);
`endif
        drive(1, 2'd1, 7, 3'd0, 2'd2, 1, 0, 0, 0, 0);
        step("rstld.issue");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rstld.wait");
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rstld.async_busy", 32'(busy), 0);
        chk("rstld.async_in_ready", 32'(in_ready), 1);
        chk("rstld.async_retire_cnt", retire_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstld.in_ready_after_release", 32'(in_ready), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1280_FF00);
        step("rstld.stale_rsp");
        chk("rstld.no_write", 32'(wr_en), 0);
        chk("rstld.retire_cnt", retire_cnt, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rstld.idle");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 2'($urandom), 5'($urandom), 3'($urandom),
                  2'($urandom), 1'($urandom), $urandom, $urandom,
                  ($urandom % 3) == 0, $urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/wb_commit_stage.md
WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 SHALL have parameter Inst_Size, default 32: datapath width.
REQ-002 SHALL have port clk  input  1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: retire-request handshake; transfer when both high at a clk edge.
REQ-005 SHALL have inputs alu_result and pc_plus4, Inst_Size each: candidate write values.
REQ-006 SHALL have inputs rd (5), func3 (3), addr_lo (2), wb_sel (2), reg_write (1): destination, load type, byte offset, source select (00 ALU, 01 load, 10 pc_plus4, 11 none), and write request.
REQ-007 SHALL have inputs mem_rsp_valid (1) and mem_rdata (Inst_Size): data-memory load response.
REQ-008 SHALL have outputs wr_en (1), wr_rd (5), write_data (Inst_Size): register-file write port, matching the decode stage's wr_en/write_data.
REQ-009 SHALL have outputs busy (1), retire_cnt (32), fwd_valid (1), fwd_rd (5), fwd_data (Inst_Size).

Function
REQ-010 SHALL implement states IDLE, WAIT_LOAD, COMMIT.
REQ-011 in_ready SHALL be 1 in IDLE and COMMIT, 0 in WAIT_LOAD.
REQ-012 On transfer with wb_sel!=01: capture rd/reg_write, compute value, go to COMMIT.
REQ-013 On transfer with wb_sel=01: capture rd/func3/addr_lo/reg_write, go to WAIT_LOAD; busy=1 while in WAIT_LOAD.
REQ-014 WAIT_LOAD: on mem_rsp_valid=1, format mem_rdata and go to COMMIT; else stay (no timeout).
REQ-015 mem_rsp_valid SHALL be ignored in IDLE and COMMIT.
REQ-016 Load formatting: 000 LB sign-extends byte addr_lo; 100 LBU zero-extends it; 001 LH sign-extends halfword addr_lo[1]; 101 LHU zero-extends it; 010 LW and all other codes pass word unchanged.
REQ-017 COMMIT lasts exactly one cycle: wr_en=reg_write AND (wb_sel!=11) AND (rd!=0); wr_rd/write_data hold captured values.
REQ-018 From COMMIT: transfer present -> per REQ-012/013 (back-to-back, one retire per cycle); otherwise IDLE.
REQ-019 Latency: non-load transfer at edge N -> wr_en high during cycle N+1; load response at edge M -> wr_en high during cycle M+1.
REQ-020 retire_cnt SHALL increment by 1 every COMMIT cycle (including rd=0 and wb_sel=11), wrapping 0xFFFFFFFF -> 0.
REQ-021 wr_en, wr_rd, write_data SHALL be 0 outside COMMIT.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, wr_en=0, wr_rd=0, write_data=0, busy=0, retire_cnt=0, fwd_valid=0, fwd_rd=0, fwd_data=0, all captured fields 0.
REQ-023 Reset during WAIT_LOAD SHALL discard the pending load; a later mem_rsp_valid SHALL cause no write.
REQ-024 in_ready SHALL be 1 the first cycle after rst_n deasserts.

Configuration
REQ-025 Macro WB_FORWARD_EN: when defined, fwd_valid=wr_en, fwd_rd=wr_rd, fwd_data=write_data (combinational, same cycle) for decode-stage bypass.
REQ-026 Without WB_FORWARD_EN, fwd_valid, fwd_rd, fwd_data SHALL be tied to 0; all other behaviour identical.

Verification
REQ-027 ALU write: in_valid, wb_sel=00, rd=5, reg_write=1, alu_result=0x0000_1234 -> next cycle wr_en=1, wr_rd=5, write_data=0x0000_1234, retire_cnt=1.
REQ-028 LB: wb_sel=01, func3=000, addr_lo=2, rd=7; 3 cycles later mem_rsp_valid, mem_rdata=0x1280_FF00 -> busy=1 and in_ready=0 until response, next cycle write_data=0xFFFF_FF80, wr_rd=7.
REQ-029 LHU addr_lo=2, mem_rdata=0x8001_0000 -> write_data=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-030 rd=0, reg_write=1, alu_result=0xDEAD_BEEF -> wr_en stays 0, retire_cnt increments.
REQ-031 Back-to-back: three ALU transfers on consecutive edges (rd=1,2,3) -> wr_en high three consecutive cycles with wr_rd 1,2,3; in_ready never drops.
REQ-032 rst_n pulled low in WAIT_LOAD, then mem_rsp_valid=1 after release -> no wr_en, retire_cnt=0; with WB_FORWARD_EN, fwd_* mirror REQ-027 write.
